// File: rtl/game_frame_sequencer_if.sv
// game_frame_sequencer_if: vsync/button inputs and game-state outputs shared with the renderer.
interface game_frame_sequencer_if;
  logic       vsync;
  logic       flap_btn;
  logic [9:0] bird_coord;
  logic [8:0] pipe_pos;
  logic [7:0] pipe_array0;
  logic [7:0] pipe_array1;
  logic [3:0] current_score;
  logic [1:0] game_state;
  logic       frame_tick;
  modport master (
    input  vsync, flap_btn,
    output bird_coord, pipe_pos, pipe_array0, pipe_array1, current_score, game_state, frame_tick
  );
  modport slave (
    output vsync, flap_btn,
    input  bird_coord, pipe_pos, pipe_array0, pipe_array1, current_score, game_state, frame_tick
  );
endinterface

// File: rtl/game_frame_sequencer.sv
// game_frame_sequencer: once-per-frame bird physics, pipe scroll/regeneration, collision and scoring.
module game_frame_sequencer #(
  parameter int         BIRD_START = 240,
  parameter int         FLAP_VEL   = 8,
  parameter int         GRAVITY    = 1,
  parameter int         MAX_FALL   = 10,
  parameter int         SCROLL     = 2,
  parameter int         PIPE_WRAP  = 345,
  parameter int         BIRD_MAX   = 459,
  parameter logic [7:0] LFSR_SEED  = 8'hB8
) (
  input logic dclk,
  input logic clr,
  game_frame_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, PLAY, DEAD, BAD} state_t;
  localparam logic [9:0]         B_START = 10'(BIRD_START);
  localparam logic signed [10:0] B_MAX   = 11'(BIRD_MAX);
  localparam logic signed [6:0]  V_FLAP  = 7'(FLAP_VEL);
  localparam logic signed [6:0]  V_GRAV  = 7'(GRAVITY);
  localparam logic signed [6:0]  V_MIN   = 7'(-MAX_FALL);
  localparam logic [9:0]         P_STEP  = 10'(SCROLL);
  localparam logic [9:0]         P_WRAP  = 10'(PIPE_WRAP);
  localparam logic [7:0]         A0_RST  = 8'd100;
  localparam logic [7:0]         A1_RST  = 8'd60;
  localparam logic [7:0]         POLY    = 8'hB8;
  state_t            state_q, state_d;
  logic [9:0]        bird_q, bird_d;
  logic [8:0]        pos_q, pos_d;
  logic [7:0]        a0_q, a0_d, a1_q, a1_d, lfsr_q, lfsr_d;
  logic [3:0]        score_q, score_d;
  logic signed [6:0] vel_q, vel_d, vel_dec;
  logic              pend_q, pend_d, tick_q, tick_d, vs_q, vs_d, arm_q, arm_d;
  logic [2:0]        sync_q, sync_d;
  logic signed [10:0] bird_sum;
  logic [9:0]        s;
  logic [10:0]       top, bot, gtop, gbot;
  logic              hit, wrap;
  always_comb begin
    vs_d = bus.vsync;
    // arm blocks a tick from a vsync that was already low when clr released
    arm_d = arm_q | bus.vsync;
    sync_d = {sync_q[1:0], bus.flap_btn};
    tick_d = arm_q & vs_q & ~bus.vsync;
    pend_d = (sync_q[1] & ~sync_q[2]) | (pend_q & ~tick_q);
    lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? POLY : 8'h00);
    top = 11'd460 - {1'b0, bird_q};
    bot = 11'd500 - {1'b0, bird_q};
    gtop = {3'b0, a0_q} + 11'd75;
    gbot = {3'b0, a0_q} + 11'd215;
    hit = bird_q == '0 || (pos_q > 9'd155 && pos_q < 9'd255 && (top < gtop || bot > gbot));
    vel_dec = vel_q - V_GRAV;
    bird_sum = $signed({1'b0, bird_q}) + $signed({{4{vel_q[6]}}, vel_q});
    s = {1'b0, pos_q} + P_STEP;
    wrap = s >= P_WRAP;
    state_d = state_q;
    bird_d = bird_q;
    pos_d = pos_q;
    a0_d = a0_q;
    a1_d = a1_q;
    score_d = score_q;
    vel_d = vel_q;
    if (tick_q) begin
      case (state_q)
        IDLE: if (pend_q) begin
          state_d = PLAY;
          vel_d = V_FLAP;
        end
        PLAY: if (hit) state_d = DEAD;
        else begin
          vel_d = pend_q ? V_FLAP : (vel_dec < V_MIN ? V_MIN : vel_dec);
          bird_d = bird_sum[10] ? '0 : (bird_sum > B_MAX ? B_MAX[9:0] : bird_sum[9:0]);
          pos_d = wrap ? 9'(s - P_WRAP) : s[8:0];
          a0_d = wrap ? a1_q : a0_q;
          a1_d = wrap ? lfsr_q : a1_q;
          score_d = (wrap && score_q != 4'hF) ? score_q + 4'd1 : score_q;
        end
        default: if (pend_q || state_q == BAD) begin
          state_d = IDLE;
          bird_d = B_START;
          pos_d = '0;
          a0_d = A0_RST;
          a1_d = A1_RST;
          score_d = '0;
          vel_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      bird_q <= B_START;
      pos_q <= '0;
      a0_q <= A0_RST;
      a1_q <= A1_RST;
      score_q <= '0;
      vel_q <= '0;
      pend_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
      tick_q <= 1'b0;
      vs_q <= 1'b1;
      arm_q <= 1'b0;
      sync_q <= '0;
    end else begin
      state_q <= state_d;
      bird_q <= bird_d;
      pos_q <= pos_d;
      a0_q <= a0_d;
      a1_q <= a1_d;
      score_q <= score_d;
      vel_q <= vel_d;
      pend_q <= pend_d;
      lfsr_q <= lfsr_d;
      tick_q <= tick_d;
      vs_q <= vs_d;
      arm_q <= arm_d;
      sync_q <= sync_d;
    end
  end
  assign bus.bird_coord = bird_q;
  assign bus.pipe_pos = pos_q;
  assign bus.pipe_array0 = a0_q;
  assign bus.pipe_array1 = a1_q;
  assign bus.current_score = score_q;
  assign bus.game_state = state_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_game_frame_sequencer.sv
// tb_game_frame_sequencer: frame-level directed vectors plus scroll/score/collision model runs.
module tb_game_frame_sequencer;
  logic dclk = 1'b0;
  logic clr = 1'b1;
  always #20 dclk = ~dclk;
  game_frame_sequencer_if g();
  game_frame_sequencer dut (.dclk(dclk), .clr(clr), .bus(g));
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] m_lfsr;
  logic [7:0] cap;
  always @(posedge dclk or posedge clr)
    if (clr) m_lfsr <= 8'hB8;
    else m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  typedef struct {
    int nfr; int np; int st; int bird; int pos; int sc; int a0; int a1;
  } vec_t;
  vec_t tv[15];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string nm, input int st, input int bird, input int pos,
                         input int sc, input int a0, input int a1);
    chk({nm, ".state"}, int'(g.game_state), st);
    chk({nm, ".bird"}, int'(g.bird_coord), bird);
    chk({nm, ".pos"}, int'(g.pipe_pos), pos);
    chk({nm, ".score"}, int'(g.current_score), sc);
    chk({nm, ".a0"}, int'(g.pipe_array0), a0);
    chk({nm, ".a1"}, int'(g.pipe_array1), a1);
  endtask
  task automatic drive(input logic vs, input logic fl, inout int nt);
    g.vsync = vs;
    g.flap_btn = fl;
    @(negedge dclk);
    if (g.frame_tick) nt++;
  endtask
  // One 12-cycle frame; np button presses land before this frame's tick.
  task automatic do_frame(input int np, output int nt);
    nt = 0;
    for (int c = 0; c < 12; c++) begin
      g.vsync = !(c == 8 || c == 9);
      g.flap_btn = (np > 0 && (c == 1 || c == 2)) || (np > 1 && (c == 5 || c == 6));
      @(negedge dclk);
      if (g.frame_tick) begin
        nt++;
        cap = m_lfsr;
      end
    end
  endtask
  task automatic model_frame(input int np, output int w);
    int pb, pp, pa0, pa1, ps, nt;
    bit hit;
    pb = g.bird_coord; pp = g.pipe_pos; pa0 = g.pipe_array0; pa1 = g.pipe_array1;
    ps = g.current_score;
    do_frame(np, nt);
    hit = pb == 0 || (pp > 155 && pp < 255 && (460 - pb < pa0 + 75 || 500 - pb > pa0 + 215));
    w = (!hit && pp + 2 >= 345) ? 1 : 0;
    chk("m_state", int'(g.game_state), hit ? 2 : 1);
    chk("m_pos", int'(g.pipe_pos), hit ? pp : (w != 0 ? pp + 2 - 345 : pp + 2));
    chk("m_a0", int'(g.pipe_array0), w != 0 ? pa1 : pa0);
    chk("m_a1", int'(g.pipe_array1), w != 0 ? int'(cap) : pa1);
    chk("m_score", int'(g.current_score), (w != 0 && ps < 15) ? ps + 1 : ps);
  endtask
  function automatic int ctl();
    return (int'(g.bird_coord) < 335 - int'(g.pipe_array0)) ? 1 : 0;
  endfunction
  initial begin
    int nt, w, wraps, fr, sb, sp, sa0, sa1, ss;
    tv[0]  = '{3, 0, 0, 240, 0, 0, 100, 60};
    tv[1]  = '{1, 1, 1, 240, 0, 0, 100, 60};
    tv[2]  = '{1, 0, 1, 248, 2, 0, 100, 60};
    tv[3]  = '{1, 0, 1, 255, 4, 0, 100, 60};
    tv[4]  = '{6, 0, 1, 276, 16, 0, 100, 60};
    tv[5]  = '{10, 0, 1, 231, 36, 0, 100, 60};
    tv[6]  = '{1, 0, 1, 221, 38, 0, 100, 60};
    tv[7]  = '{22, 0, 1, 1, 82, 0, 100, 60};
    tv[8]  = '{1, 0, 1, 0, 84, 0, 100, 60};
    tv[9]  = '{1, 0, 2, 0, 84, 0, 100, 60};
    tv[10] = '{2, 0, 2, 0, 84, 0, 100, 60};
    tv[11] = '{1, 1, 0, 240, 0, 0, 100, 60};
    tv[12] = '{1, 2, 1, 240, 0, 0, 100, 60};
    tv[13] = '{1, 0, 1, 248, 2, 0, 100, 60};
    tv[14] = '{1, 0, 1, 255, 4, 0, 100, 60};
    g.vsync = 1'b1;
    g.flap_btn = 1'b0;
    repeat (3) @(negedge dclk);
    clr = 1'b0;
    chk_all("reset", 0, 240, 0, 0, 100, 60);
    chk("reset.tick", int'(g.frame_tick), 0);
    for (int i = 0; i < 15; i++) begin
      int tot;
      tot = 0;
      for (int f = 0; f < tv[i].nfr; f++) begin
        do_frame(f == 0 ? tv[i].np : 0, nt);
        tot += nt;
      end
      chk($sformatf("vec%0d.ticks", i), tot, tv[i].nfr);
      chk_all($sformatf("vec%0d", i), tv[i].st, tv[i].bird, tv[i].pos, tv[i].sc, tv[i].a0, tv[i].a1);
    end
    wraps = 0;
    fr = 0;
    while (wraps < 16 && g.game_state == 2'd1 && fr < 4000) begin
      model_frame(ctl(), w);
      wraps += w;
      fr++;
    end
    chk("wraps", wraps, 16);
    chk("sat_score", int'(g.current_score), 15);
    fr = 0;
    while (!(g.pipe_pos >= 9'd170 && g.pipe_pos <= 9'd230) && g.game_state == 2'd1 && fr < 400) begin
      model_frame(ctl(), w);
      fr++;
    end
    chk("overlap_reached", int'(g.game_state), 1);
    fr = 0;
    while (g.game_state == 2'd1 && fr < 20) begin
      model_frame(1, w);
      fr++;
    end
    chk("pipe_hit.state", int'(g.game_state), 2);
    chk("pipe_hit.above_ground", int'(g.bird_coord != 10'd0), 1);
    sb = g.bird_coord; sp = g.pipe_pos; sa0 = g.pipe_array0; sa1 = g.pipe_array1;
    ss = g.current_score;
    repeat (2) begin
      do_frame(0, nt);
      chk_all("frozen", 2, sb, sp, ss, sa0, sa1);
    end
    do_frame(1, nt);
    chk_all("dead_restart", 0, 240, 0, 0, 100, 60);
    nt = 0;
    repeat (4) drive(1'b1, 1'b0, nt);
    drive(1'b1, 1'b1, nt);
    drive(1'b0, 1'b1, nt);
    drive(1'b0, 1'b0, nt);
    repeat (6) drive(1'b1, 1'b0, nt);
    chk("same_cycle.ticks", nt, 1);
    chk("same_cycle.idle", int'(g.game_state), 0);
    do_frame(0, nt);
    chk_all("same_cycle.kept", 1, 240, 0, 0, 100, 60);
    do_frame(0, nt);
    g.vsync = 1'b0;
    #7 clr = 1'b1;
    #1 chk_all("async_clr", 0, 240, 0, 0, 100, 60);
    @(negedge dclk);
    clr = 1'b0;
    nt = 0;
    repeat (4) drive(1'b0, 1'b0, nt);
    chk("low_at_release.ticks", nt, 0);
    nt = 0;
    repeat (3) drive(1'b1, 1'b0, nt);
    repeat (3) drive(1'b0, 1'b0, nt);
    chk("next_fall.ticks", nt, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
